// File: rtl/gpio_irq_master_if.sv
// gpio_irq_master_if
//   Avalon-MM bus between gpio_irq_master and prog_gpio, plus the GPIO
//   interrupt line that travels back to the master.
//   avm_address     5   byte address of the GPIO register
//   avm_read        1   read strobe
//   avm_write       1   write strobe
//   avm_writedata   32  write data
//   avm_readdata    32  read data, valid when read is accepted
//   avm_waitrequest 1   slave stall
//   irq             1   level interrupt, held until IRQ_ACK is written
interface gpio_irq_master_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        irq;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest, irq
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest, irq
    );
endinterface

// File: rtl/gpio_irq_master.sv
// gpio_irq_master
//   Programs a prog_gpio instance after reset (ENA, IRQ_POL, IRQ_MASK), then
//   services each interrupt by reading DATA and writing IRQ_ACK, and queues
//   the captured word in a small FIFO exposed as a valid/ready stream.
//   clk        1   clock, rising edge
//   reset      1   asynchronous active-high reset
//   avm        -   Avalon-MM master bus + irq (gpio_irq_master_if.master)
//   evt_data   32  word at FIFO head
//   evt_valid  1   FIFO not empty
//   evt_ready  1   consumer pops the head when evt_valid && evt_ready
//   init_done  1   all three init writes have completed
//   drop_count 16  events lost to a full FIFO, saturating
module gpio_irq_master #(
    parameter logic [31:0] ENA_INIT     = 32'h0000_ffff,
    parameter logic [31:0] POL_INIT     = 32'h0000_0000,
    parameter logic [31:0] MASK_INIT    = 32'h0000_0003,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    gpio_irq_master_if.master        avm,
    output logic [31:0]              evt_data,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic                     init_done,
    output logic [15:0]              drop_count
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [4:0] ADDR_DATA = 5'h00;
    localparam logic [4:0] ADDR_ENA  = 5'h04;
    localparam logic [4:0] ADDR_MASK = 5'h08;
    localparam logic [4:0] ADDR_POL  = 5'h0c;
    localparam logic [4:0] ADDR_ACK  = 5'h10;

    localparam logic [AW:0]   FULL_COUNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(32'd1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(32'd1);
    localparam logic [3:0]    GUARD_LOAD = 4'(GUARD_CYCLES - 32'd1);

    typedef enum logic [2:0] {
        W_ENA   = 3'd0,
        W_POL   = 3'd1,
        W_MASK  = 3'd2,
        IDLE    = 3'd3,
        RD_DATA = 3'd4,
        W_ACK   = 3'd5,
        GUARD   = 3'd6
    } state_t;

    state_t          state_r;
    logic [3:0]      guard_cnt_r;
    logic [31:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;

    logic            bus_done_s;
    logic            pop_s;
    logic            capture_s;
    logic            push_s;
    logic            drop_s;

    assign evt_valid = (count_r != {(AW + 1){1'b0}});
    assign evt_data  = mem_r[rd_ptr_r];

    // Transfer completion, FIFO pop and push/drop decision for a captured word.
    always_comb begin
        bus_done_s = (avm.avm_read | avm.avm_write) & ~avm.avm_waitrequest;
        pop_s      = evt_valid & evt_ready;
        capture_s  = (state_r == RD_DATA) & avm.avm_read & bus_done_s;
        if (capture_s) begin
            // A same-cycle pop frees a slot, so a full FIFO still accepts the word.
            push_s = (count_r != FULL_COUNT) | pop_s;
            drop_s = ~push_s;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Control FSM: init writes, interrupt service and post-ACK guard window.
    // Each bus state is entered with its strobe/address/data already loaded,
    // so back-to-back transfers need no idle cycle in between.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= W_ENA;
            guard_cnt_r       <= 4'd0;
            init_done         <= 1'b0;
            avm.avm_read      <= 1'b0;
            avm.avm_write     <= 1'b0;
            avm.avm_address   <= 5'h00;
            avm.avm_writedata <= 32'h0000_0000;
        end else begin
            case (state_r)
                W_ENA: begin
                    if (!avm.avm_write) begin
                        // Only reached on the first cycle after reset.
                        avm.avm_write     <= 1'b1;
                        avm.avm_address   <= ADDR_ENA;
                        avm.avm_writedata <= ENA_INIT;
                    end else if (bus_done_s) begin
                        avm.avm_address   <= ADDR_POL;
                        avm.avm_writedata <= POL_INIT;
                        state_r           <= W_POL;
                    end else begin
                        state_r <= W_ENA;
                    end
                end
                W_POL: begin
                    if (bus_done_s) begin
                        avm.avm_address   <= ADDR_MASK;
                        avm.avm_writedata <= MASK_INIT;
                        state_r           <= W_MASK;
                    end else begin
                        state_r <= W_POL;
                    end
                end
                W_MASK: begin
                    if (bus_done_s) begin
                        avm.avm_write     <= 1'b0;
                        avm.avm_address   <= 5'h00;
                        avm.avm_writedata <= 32'h0000_0000;
                        init_done         <= 1'b1;
                        state_r           <= IDLE;
                    end else begin
                        state_r <= W_MASK;
                    end
                end
                IDLE: begin
                    if (avm.irq) begin
                        avm.avm_read    <= 1'b1;
                        avm.avm_address <= ADDR_DATA;
                        state_r         <= RD_DATA;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (bus_done_s) begin
                        avm.avm_read      <= 1'b0;
                        avm.avm_write     <= 1'b1;
                        avm.avm_address   <= ADDR_ACK;
                        avm.avm_writedata <= 32'h0000_0000;
                        state_r           <= W_ACK;
                    end else begin
                        state_r <= RD_DATA;
                    end
                end
                W_ACK: begin
                    if (bus_done_s) begin
                        avm.avm_write   <= 1'b0;
                        avm.avm_address <= 5'h00;
                        guard_cnt_r     <= GUARD_LOAD;
                        state_r         <= GUARD;
                    end else begin
                        state_r <= W_ACK;
                    end
                end
                GUARD: begin
                    // irq is ignored here: prog_gpio may still show the old level.
                    if (guard_cnt_r == 4'd0) begin
                        state_r <= IDLE;
                    end else begin
                        guard_cnt_r <= guard_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r           <= W_ENA;
                    avm.avm_read      <= 1'b0;
                    avm.avm_write     <= 1'b0;
                    avm.avm_address   <= 5'h00;
                    avm.avm_writedata <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Event FIFO storage, pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW + 1){1'b0}};
            drop_count <= 16'h0000;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= avm.avm_readdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s && (drop_count != 16'hffff)) begin
                drop_count <= drop_count + 16'd1;
            end else begin
                drop_count <= drop_count;
            end
        end
    end
endmodule
